// File: rtl/axi_master_arb_if.sv
// Single AXI4 master bus (AR/R/AW/W/B) shared by IFU and LSU.
// The master modport is the arbiter side and the slave modport is the downstream side.
interface axi_master_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              arvalid, arready;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              rvalid, rready, rlast;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic [3:0]        rid;
   logic              awvalid, awready;
   logic [ADDR_W-1:0] awaddr;
   logic [3:0]        awid;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              wvalid, wready, wlast;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic              bvalid, bready;
   logic [1:0]        bresp;
   logic [3:0]        bid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast, bready,
      input  arready, rvalid, rdata, rresp, rlast, rid,
      input  awready, wready, bvalid, bresp, bid
   );
   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast, bready,
      output arready, rvalid, rdata, rresp, rlast, rid,
      output awready, wready, bvalid, bresp, bid
   );
endinterface

// File: rtl/axi_master_arb.sv
// Single-outstanding, single-beat arbiter sharing one AXI4 master port between IFU reads
// and LSU reads/writes, with fixed priority LSU write > LSU read > IFU read.
module axi_master_arb #(
   parameter int          ADDR_W = 32,
   parameter int          DATA_W = 32,
   parameter logic [3:0]  IFU_ID = 4'h0,
   parameter logic [3:0]  LSU_ID = 4'h1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                f_ar_valid_i,
   output logic                f_ar_ready_o,
   input  logic [ADDR_W-1:0]   f_ar_addr_i,
   output logic                f_r_valid_o,
   input  logic                f_r_ready_i,
   output logic [DATA_W-1:0]   f_r_data_o,
   output logic [1:0]          f_r_resp_o,
   input  logic                l_ar_valid_i,
   output logic                l_ar_ready_o,
   input  logic [ADDR_W-1:0]   l_ar_addr_i,
   input  logic [2:0]          l_ar_size_i,
   output logic                l_r_valid_o,
   input  logic                l_r_ready_i,
   output logic [DATA_W-1:0]   l_r_data_o,
   output logic [1:0]          l_r_resp_o,
   input  logic                l_aw_valid_i,
   output logic                l_aw_ready_o,
   input  logic [ADDR_W-1:0]   l_aw_addr_i,
   input  logic [2:0]          l_aw_size_i,
   input  logic [DATA_W-1:0]   l_w_data_i,
   input  logic [DATA_W/8-1:0] l_w_strb_i,
   output logic                l_b_valid_o,
   input  logic                l_b_ready_i,
   output logic [1:0]          l_b_resp_o,
   axi_master_arb_if.master    io_master
);
   typedef enum logic [2:0] {IDLE, F_AR, F_R, L_AR, L_R, L_WR, L_B} state_t;

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_size;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_strb;
   logic                r_aw_done, r_w_done;
   logic                w_unused;

   always_ff @(posedge clk_i) begin
      if (!rst_i) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next               = r_state;
      f_ar_ready_o         = 1'b0;
      l_ar_ready_o         = 1'b0;
      l_aw_ready_o         = 1'b0;
      f_r_valid_o          = 1'b0;
      l_r_valid_o          = 1'b0;
      l_b_valid_o          = 1'b0;
      io_master.arvalid    = 1'b0;
      io_master.rready     = 1'b0;
      io_master.awvalid    = 1'b0;
      io_master.wvalid     = 1'b0;
      io_master.bready     = 1'b0;
      case (r_state)
         IDLE: if (rst_i) begin
            // Readies are gated by reset so nothing is granted while the core is held.
            if (l_aw_valid_i)      begin l_aw_ready_o = 1'b1; w_next = L_WR; end
            else if (l_ar_valid_i) begin l_ar_ready_o = 1'b1; w_next = L_AR; end
            else if (f_ar_valid_i) begin f_ar_ready_o = 1'b1; w_next = F_AR; end
         end
         F_AR: begin
            io_master.arvalid = 1'b1;
            if (io_master.arready) w_next = F_R;
         end
         L_AR: begin
            io_master.arvalid = 1'b1;
            if (io_master.arready) w_next = L_R;
         end
         F_R: begin
            io_master.rready = f_r_ready_i;
            f_r_valid_o      = io_master.rvalid;
            if (io_master.rvalid && f_r_ready_i) w_next = IDLE;
         end
         L_R: begin
            io_master.rready = l_r_ready_i;
            l_r_valid_o      = io_master.rvalid;
            if (io_master.rvalid && l_r_ready_i) w_next = IDLE;
         end
         L_WR: begin
            io_master.awvalid = !r_aw_done;
            io_master.wvalid  = !r_w_done;
            if ((r_aw_done || io_master.awready) && (r_w_done || io_master.wready))
               w_next = L_B;
         end
         L_B: begin
            io_master.bready = l_b_ready_i;
            l_b_valid_o      = io_master.bvalid;
            if (io_master.bvalid && l_b_ready_i) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_addr    <= '0;
         r_size    <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (l_aw_ready_o) begin
            r_addr  <= l_aw_addr_i;
            r_size  <= l_aw_size_i;
            r_wdata <= l_w_data_i;
            r_strb  <= l_w_strb_i;
         end else if (l_ar_ready_o) begin
            r_addr <= l_ar_addr_i;
            r_size <= l_ar_size_i;
         end else if (f_ar_ready_o) begin
            r_addr <= f_ar_addr_i;
            r_size <= 3'b010;
         end
         // ready only matters while the matching valid is up, and valid = !done
         if (r_state == L_WR && w_next == L_WR) begin
            r_aw_done <= r_aw_done | io_master.awready;
            r_w_done  <= r_w_done  | io_master.wready;
         end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
      end
   end

   assign io_master.araddr  = r_addr;
   assign io_master.arid    = (r_state == F_AR) ? IFU_ID : LSU_ID;
   assign io_master.arlen   = 8'd0;
   assign io_master.arsize  = r_size;
   assign io_master.arburst = 2'b01;
   assign io_master.awaddr  = r_addr;
   assign io_master.awid    = LSU_ID;
   assign io_master.awlen   = 8'd0;
   assign io_master.awsize  = r_size;
   assign io_master.awburst = 2'b01;
   assign io_master.wdata   = r_wdata;
   assign io_master.wstrb   = r_strb;
   assign io_master.wlast   = 1'b1;

   // A response carrying someone else's ID is reported as SLVERR.
   assign f_r_data_o = io_master.rdata;
   assign l_r_data_o = io_master.rdata;
   assign f_r_resp_o = (io_master.rid == IFU_ID) ? io_master.rresp : 2'b10;
   assign l_r_resp_o = (io_master.rid == LSU_ID) ? io_master.rresp : 2'b10;
   assign l_b_resp_o = (io_master.bid == LSU_ID) ? io_master.bresp : 2'b10;
   assign w_unused   = io_master.rlast;
endmodule

// File: tb/tb_axi_master_arb.sv
// Bench for axi_master_arb: the bench plays the downstream slave and the requesters,
// and predicts grants, channel contents and routed responses from the arbitration rules.
module tb_axi_master_arb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_ar_valid, f_ar_ready, f_r_valid, f_r_ready;
   logic [31:0] f_ar_addr, f_r_data;
   logic [1:0]  f_r_resp;
   logic        l_ar_valid, l_ar_ready, l_r_valid, l_r_ready;
   logic [31:0] l_ar_addr, l_r_data;
   logic [2:0]  l_ar_size;
   logic [1:0]  l_r_resp;
   logic        l_aw_valid, l_aw_ready, l_b_valid, l_b_ready;
   logic [31:0] l_aw_addr, l_w_data;
   logic [2:0]  l_aw_size;
   logic [3:0]  l_w_strb;
   logic [1:0]  l_b_resp;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   axi_master_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_master_arb #(.ADDR_W(32), .DATA_W(32), .IFU_ID(4'h0), .LSU_ID(4'h1)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .f_ar_valid_i(f_ar_valid), .f_ar_ready_o(f_ar_ready), .f_ar_addr_i(f_ar_addr),
      .f_r_valid_o(f_r_valid), .f_r_ready_i(f_r_ready), .f_r_data_o(f_r_data), .f_r_resp_o(f_r_resp),
      .l_ar_valid_i(l_ar_valid), .l_ar_ready_o(l_ar_ready), .l_ar_addr_i(l_ar_addr), .l_ar_size_i(l_ar_size),
      .l_r_valid_o(l_r_valid), .l_r_ready_i(l_r_ready), .l_r_data_o(l_r_data), .l_r_resp_o(l_r_resp),
      .l_aw_valid_i(l_aw_valid), .l_aw_ready_o(l_aw_ready), .l_aw_addr_i(l_aw_addr), .l_aw_size_i(l_aw_size),
      .l_w_data_i(l_w_data), .l_w_strb_i(l_w_strb),
      .l_b_valid_o(l_b_valid), .l_b_ready_i(l_b_ready), .l_b_resp_o(l_b_resp),
      .io_master(bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic quiet_outs(input string tag);
      chk({tag, "_arvalid"}, bus.arvalid, 0);
      chk({tag, "_awvalid"}, bus.awvalid, 0);
      chk({tag, "_wvalid"},  bus.wvalid, 0);
      chk({tag, "_rready"},  bus.rready, 0);
      chk({tag, "_bready"},  bus.bready, 0);
      chk({tag, "_f_rvalid"}, f_r_valid, 0);
      chk({tag, "_l_rvalid"}, l_r_valid, 0);
      chk({tag, "_l_bvalid"}, l_b_valid, 0);
   endtask

   task automatic no_grants(input string tag);
      chk({tag, "_f_arready"}, f_ar_ready, 0);
      chk({tag, "_l_arready"}, l_ar_ready, 0);
      chk({tag, "_l_awready"}, l_aw_ready, 0);
   endtask

   // One complete transaction. req = {l_aw, l_ar, f_ar}; hold_f keeps a losing IFU request up.
   task automatic txn(input logic [2:0] req, input bit hold_f, input logic [31:0] fa,
                      input logic [31:0] la, input logic [2:0] ls, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] rd, input logic [3:0] rsp_id,
                      input logic [1:0] rsp, input int da, input int dw, input int dr, input int dq);
      int win, n;
      logic [31:0] ea;
      logic [2:0]  es;
      logic [3:0]  eid;
      logic [1:0]  eresp;
      bit          keep_f;
      win = req[2] ? 2 : (req[1] ? 1 : 0);
      if (win == 0)      begin ea = fa; es = 3'd2; eid = 4'h0; end
      else if (win == 1) begin ea = la; es = ls; eid = 4'h1; end
      else               begin ea = la ^ 32'h40; es = ls ^ 3'd1; eid = 4'h1; end
      eresp  = (rsp_id == eid) ? rsp : 2'b10;
      keep_f = hold_f && req[0] && win != 0;

      l_aw_valid = req[2]; l_aw_addr = la ^ 32'h40; l_aw_size = ls ^ 3'd1;
      l_w_data = wd; l_w_strb = ws;
      l_ar_valid = req[1]; l_ar_addr = la; l_ar_size = ls;
      f_ar_valid = req[0]; f_ar_addr = fa;
      settle();
      chk("grant_aw", l_aw_ready, win == 2);
      chk("grant_ar", l_ar_ready, win == 1);
      chk("grant_f",  f_ar_ready, win == 0);
      quiet_outs("accept");
      step();
      // scramble request inputs so only latched values can reach the bus
      l_aw_valid = 1'b0; l_ar_valid = 1'b0;
      l_aw_addr = $urandom; l_ar_addr = $urandom; l_w_data = $urandom;
      l_w_strb = 4'($urandom); l_aw_size = 3'($urandom); l_ar_size = 3'($urandom);
      if (!keep_f) begin f_ar_valid = 1'b0; f_ar_addr = $urandom; end

      if (win == 2) begin
         n = (da > dw) ? da : dw;
         for (int k = 0; k <= n; k++) begin
            bus.awready = (k == da); bus.wready = (k == dw);
            settle();
            chk("awvalid", bus.awvalid, k <= da);
            chk("wvalid",  bus.wvalid,  k <= dw);
            chk("awaddr",  bus.awaddr, ea);
            chk("awsize",  bus.awsize, es);
            chk("awid",    bus.awid, 4'h1);
            chk("awlen",   bus.awlen, 8'd0);
            chk("awburst", bus.awburst, 2'b01);
            chk("wdata",   bus.wdata, wd);
            chk("wstrb",   bus.wstrb, ws);
            chk("wlast",   bus.wlast, 1'b1);
            chk("wr_arvalid", bus.arvalid, 0);
            chk("wr_bready",  bus.bready, 0);
            no_grants("wr");
            step();
         end
         bus.awready = 1'b0; bus.wready = 1'b0;
         n = (dr > dq) ? dr : dq;
         for (int j = 0; j <= n; j++) begin
            bus.bvalid = (j >= dr); bus.bid = rsp_id; bus.bresp = rsp; l_b_ready = (j >= dq);
            settle();
            chk("bready",  bus.bready, l_b_ready);
            chk("l_bvalid", l_b_valid, bus.bvalid);
            chk("b_f_rvalid", f_r_valid, 0);
            chk("b_l_rvalid", l_r_valid, 0);
            chk("b_awvalid", bus.awvalid, 0);
            chk("b_wvalid",  bus.wvalid, 0);
            no_grants("b");
            if (j == n) chk("l_bresp", l_b_resp, eresp);
            step();
         end
      end else begin
         for (int k = 0; k <= da; k++) begin
            bus.arready = (k == da);
            settle();
            chk("arvalid", bus.arvalid, 1);
            chk("araddr",  bus.araddr, ea);
            chk("arid",    bus.arid, eid);
            chk("arsize",  bus.arsize, es);
            chk("arlen",   bus.arlen, 8'd0);
            chk("arburst", bus.arburst, 2'b01);
            chk("ar_awvalid", bus.awvalid, 0);
            chk("ar_wvalid",  bus.wvalid, 0);
            chk("ar_rready",  bus.rready, 0);
            chk("ar_f_rvalid", f_r_valid, 0);
            chk("ar_l_rvalid", l_r_valid, 0);
            no_grants("ar");
            step();
         end
         bus.arready = 1'b0;
         n = (dr > dq) ? dr : dq;
         for (int j = 0; j <= n; j++) begin
            bus.rvalid = (j >= dr); bus.rdata = rd; bus.rid = rsp_id; bus.rresp = rsp; bus.rlast = 1'b1;
            if (win == 0) f_r_ready = (j >= dq); else l_r_ready = (j >= dq);
            settle();
            chk("rready", bus.rready, (win == 0) ? f_r_ready : l_r_ready);
            chk("f_rvalid", f_r_valid, (win == 0) ? bus.rvalid : 1'b0);
            chk("l_rvalid", l_r_valid, (win == 1) ? bus.rvalid : 1'b0);
            chk("r_l_bvalid", l_b_valid, 0);
            chk("r_arvalid", bus.arvalid, 0);
            no_grants("r");
            if (j == n) begin
               chk("rdata", (win == 0) ? f_r_data : l_r_data, rd);
               chk("rresp", (win == 0) ? f_r_resp : l_r_resp, eresp);
            end
            step();
         end
      end
      if (!keep_f) begin
         // a lingering response beat must not be handed to anyone once back in IDLE
         settle();
         quiet_outs("after");
         no_grants("after");
         step();
      end
      bus.rvalid = 1'b0; bus.bvalid = 1'b0;
      f_r_ready = 1'b0; l_r_ready = 1'b0; l_b_ready = 1'b0;
   endtask

   initial begin
      logic [2:0]  req;
      logic [3:0]  rid;
      rst_n = 1'b0;
      f_ar_valid = 1'b1; f_ar_addr = 32'h1234_5678; f_r_ready = 1'b0;
      l_ar_valid = 1'b0; l_ar_addr = '0; l_ar_size = '0; l_r_ready = 1'b0;
      l_aw_valid = 1'b0; l_aw_addr = '0; l_aw_size = '0; l_w_data = '0; l_w_strb = '0; l_b_ready = 1'b0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;

      step(); step();
      settle();
      quiet_outs("reset");
      no_grants("reset");
      chk("reset_araddr", bus.araddr, 32'h0);
      chk("reset_wdata",  bus.wdata, 32'h0);
      chk("reset_wstrb",  bus.wstrb, 4'h0);
      chk("reset_arsize", bus.arsize, 3'h0);
      f_ar_valid = 1'b0;
      rst_n = 1'b1;
      step();

      txn(3'b001, 0, 32'h8000_0000, 32'h0, 3'd0, 32'h0, 4'h0, 32'h0000_0413, 4'h0, 2'b00, 0, 0, 0, 0);
      txn(3'b011, 1, 32'h8000_0004, 32'h8000_1000, 3'd0, 32'h0, 4'h0, 32'hCAFE_0001, 4'h1, 2'b00, 0, 0, 1, 0);
      txn(3'b001, 0, 32'h8000_0004, 32'h0, 3'd0, 32'h0, 4'h0, 32'h0000_0013, 4'h0, 2'b00, 0, 0, 0, 0);
      txn(3'b100, 0, 32'h0, 32'h1000_0000, 3'd2, 32'hDEAD_BEEF, 4'b0011, 32'h0, 4'h1, 2'b00, 0, 2, 0, 0);
      txn(3'b001, 0, 32'h8000_0100, 32'h0, 3'd0, 32'h0, 4'h0, 32'h1111_2222, 4'h0, 2'b00, 5, 0, 0, 3);
      txn(3'b001, 0, 32'h8000_0200, 32'h0, 3'd0, 32'h0, 4'h0, 32'h3333_4444, 4'h3, 2'b00, 0, 0, 0, 0);

      // reset while the write data is still outstanding
      l_aw_valid = 1'b1; l_aw_addr = 32'h2000_0000; l_aw_size = 3'd2; l_w_data = 32'h5555_AAAA; l_w_strb = 4'hF;
      settle();
      chk("rst_grant", l_aw_ready, 1);
      step();
      l_aw_valid = 1'b0;
      bus.awready = 1'b1; bus.wready = 1'b0;
      settle();
      chk("rst_awvalid0", bus.awvalid, 1);
      chk("rst_wvalid0",  bus.wvalid, 1);
      step();
      bus.awready = 1'b0;
      settle();
      chk("rst_awvalid1", bus.awvalid, 0);
      chk("rst_wvalid1",  bus.wvalid, 1);
      rst_n = 1'b0; f_ar_valid = 1'b1; l_ar_valid = 1'b1;
      step();
      settle();
      quiet_outs("rst_mid");
      no_grants("rst_mid");
      rst_n = 1'b1; f_ar_valid = 1'b0; l_ar_valid = 1'b0;
      step();

      for (int t = 0; t < 40; t++) begin
         req = 3'($urandom_range(1, 7));
         rid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
         txn(req, 0, $urandom, $urandom, 3'($urandom_range(0, 2)), $urandom, 4'($urandom), $urandom,
             rid, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
